d_latch: RTL and testbench
==========================

Name: d_latch

Overview:
- Clocked, enable-gated data-holding element: the registered equivalent of a transparent D latch, with true and complement outputs.
- When EN is high, Q tracks D one clock later. When EN is low, Q holds its last value.
- Used as a generic hold/capture cell wherever a level-enabled storage bit (or bus) is needed inside the synchronous clock domain. It is not a true level-sensitive latch, so there are no timing loops.

Parameters:
- WIDTH, 1, bit width of D, Q and Qbar.
- RST_VAL, 0 (WIDTH bits), value loaded into Q on reset.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- D  input  WIDTH  data input.
- EN  input  1  enable; 1 = track D, 0 = hold.
- Q  output  WIDTH  stored value (registered).
- Qbar  output  WIDTH  bitwise complement of Q.
- upd  output  1  one-cycle pulse, high in the cycle after Q changed value.

Behaviour:
- Reset (rst=1, asynchronous assert and release synchronised to clk by the reset tree):
  - Q = RST_VAL immediately, independent of clk.
  - Qbar = ~RST_VAL.
  - upd = 0.
  - The reset state holds for as long as rst is high.
  - D and EN are ignored during reset.
- On each rising clk with rst=0:
  - EN=1: Q <= D, sampled at that edge. Latency from D/EN change to Q is 1 clock edge.
  - EN=0: Q <= Q (hold). Any number of D toggles while EN=0 has no effect.
- Qbar:
  - Purely combinational: Qbar = ~Q at all times, including during reset.
  - Never equal to Q on any bit; no X on Qbar once rst has been asserted.
- upd:
  - Registered.
  - Set to 1 at an edge where EN=1 and D differs from the current Q; otherwise 0.
  - EN=1 with D equal to Q gives upd=0.
- Simultaneous events:
  - D and EN changing in the same cycle: the value sampled at the next edge decides.
  - Example: EN falling 1->0 together with a D change means Q keeps the old value.
  - EN rising with a new D means Q takes the new D.
- Reset mid-operation: rst overrides EN and D instantly. After release, the first rising edge with EN=1 loads D.
- Width rules: all bits are handled independently and identically. No arithmetic, no sign handling.
- Before the first reset, Q is undefined. The bench must assert rst at time 0.

Test Plan:
- Reset: rst=1 with D=1, EN=1 -> Q=0, Qbar=1, upd=0 during reset with no clock edge required. Release rst -> at the next edge Q=1, Qbar=0, upd=1.
- Track: EN=1, D=1 for 2 cycles, then D=0 -> Q=1 one edge after D=1, then Q=0 one edge after D=0. Qbar is always the complement. upd pulses once per change.
- Hold: after Q=0 with EN=1, drive D=1, EN=0 and then D=0, EN=0 over 4 cycles -> Q stays 0, Qbar stays 1, upd stays 0 throughout.
- Re-enable: from hold with Q=0, drive D=1, EN=1 -> Q=1 at the next edge, upd=1 for exactly one cycle.
- Simultaneous: Q=1, EN=1, then in one cycle D=0 and EN=0 -> Q remains 1. Separately, with Q=0 and EN=0, set EN=1 and D=1 together -> Q=1 at the next edge.
- Async reset mid-run: Q=1, EN=1, D=1, assert rst between clock edges -> Q=0 and Qbar=1 immediately, before the next edge. Release with EN=0 -> Q holds 0.

Source files
------------

// File: rtl/d_latch.sv
// Clocked, enable-gated hold cell: the synchronous equivalent of a transparent D latch.
// Q follows D one edge later while EN is high; Qbar is the live complement of Q.
module d_latch #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             upd
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             upd_q, upd_d;

    always_comb begin
        // NOTE: defaults first so every path assigns q_d/upd_d and no latch is inferred.
        q_d   = q_q;
        upd_d = 1'b0;
        if (EN) begin
            q_d   = D;
            upd_d = (D != q_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so all flops update together from pre-edge values.
        if (rst) begin
            q_q   <= RST_VAL;
            upd_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            upd_q <= upd_d;
        end
    end

    assign Q    = q_q;
    assign Qbar = ~q_q;
    assign upd  = upd_q;

endmodule

// File: tb/tb_d_latch.sv
// Self-checking bench for d_latch: directed scenarios plus random traffic against a
// reference model that only remembers the last value loaded since reset.
module tb_d_latch;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] D;
    logic         EN;
    logic [W-1:0] Q;
    logic [W-1:0] Qbar;
    logic         upd;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: stored value and whether the last edge changed it.
    logic [W-1:0] m_q;
    logic         m_upd;

    d_latch #(.WIDTH(W), .RST_VAL('0)) dut (
        .clk (clk),
        .rst (rst),
        .D   (D),
        .EN  (EN),
        .Q   (Q),
        .Qbar(Qbar),
        .upd (upd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply inputs for one cycle, advance the model at the edge, return at the next falling edge.
    task automatic drive_cycle(input logic [W-1:0] d, input logic en);
        logic [W-1:0] prev;
        D  = d;
        EN = en;
        @(posedge clk);
        if (rst) begin
            m_q   = '0;
            m_upd = 1'b0;
        end else if (en) begin
            prev  = m_q;
            m_q   = d;
            m_upd = (prev != d);
        end else begin
            m_upd = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        D   = '1;
        EN  = 1'b1;
        #2;
        n_checks++;
        if (Q !== 4'h0 || Qbar !== 4'hF || upd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: Q=%h Qbar=%h upd=%b, want Q=0 Qbar=F upd=0", Q, Qbar, upd);
        end
        @(negedge clk);
        n_checks++;
        if (Q !== 4'h0 || upd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: Q=%h upd=%b, want Q=0 upd=0", Q, upd);
        end
        rst   = 1'b0;
        m_q   = '0;
        m_upd = 1'b0;
        drive_cycle(4'h1, 1'b1);
        n_checks++;
        if (Q !== 4'h1 || Qbar !== 4'hE || upd !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: Q=%h Qbar=%h upd=%b, want Q=1 Qbar=E upd=1", Q, Qbar, upd);
        end
    endtask

    task automatic test_track();
        logic [W-1:0] seq [4] = '{4'h1, 4'h0, 4'h0, 4'hA};
        logic         exp_upd [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(seq[i], 1'b1);
            n_checks++;
            if (Q !== seq[i] || Qbar !== ~seq[i] || upd !== exp_upd[i]) begin
                n_fail++;
                $display("FAIL track[%0d]: Q=%h Qbar=%h upd=%b, want Q=%h upd=%b",
                         i, Q, Qbar, upd, seq[i], exp_upd[i]);
            end
        end
        drive_cycle(4'h0, 1'b1);
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) begin
            drive_cycle((i % 2 == 0) ? 4'hF : 4'h0, 1'b0);
            n_checks++;
            if (Q !== 4'h0 || Qbar !== 4'hF || upd !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: Q=%h Qbar=%h upd=%b, want Q=0 Qbar=F upd=0", i, Q, Qbar, upd);
            end
        end
    endtask

    task automatic test_reenable();
        drive_cycle(4'h1, 1'b1);
        n_checks++;
        if (Q !== 4'h1 || upd !== 1'b1) begin
            n_fail++;
            $display("FAIL reenable_load: Q=%h upd=%b, want Q=1 upd=1", Q, upd);
        end
        drive_cycle(4'h1, 1'b1);
        n_checks++;
        if (Q !== 4'h1 || upd !== 1'b0) begin
            n_fail++;
            $display("FAIL reenable_pulse_width: Q=%h upd=%b, want Q=1 upd=0", Q, upd);
        end
    endtask

    task automatic test_simultaneous();
        drive_cycle(4'h0, 1'b0);
        n_checks++;
        if (Q !== 4'h1 || upd !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_en_fall: Q=%h upd=%b, want Q=1 upd=0", Q, upd);
        end
        drive_cycle(4'h0, 1'b1);
        drive_cycle(4'h0, 1'b0);
        drive_cycle(4'h1, 1'b1);
        n_checks++;
        if (Q !== 4'h1 || upd !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_en_rise: Q=%h upd=%b, want Q=1 upd=1", Q, upd);
        end
    endtask

    task automatic test_async_reset_mid_run();
        drive_cycle(4'h0, 1'b1);
        drive_cycle(4'h1, 1'b1);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (Q !== 4'h0 || Qbar !== 4'hF || upd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: Q=%h Qbar=%h upd=%b, want Q=0 Qbar=F upd=0", Q, Qbar, upd);
        end
        @(negedge clk);
        rst   = 1'b0;
        m_q   = '0;
        m_upd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(W'($urandom_range(1, 15)), 1'b0);
            n_checks++;
            if (Q !== 4'h0 || upd !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_hold[%0d]: Q=%h upd=%b, want Q=0 upd=0", i, Q, upd);
            end
        end
        drive_cycle(4'h6, 1'b1);
        n_checks++;
        if (Q !== 4'h6 || upd !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_load: Q=%h upd=%b, want Q=6 upd=1", Q, upd);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            drive_cycle(W'($urandom), 1'($urandom_range(0, 1)));
            rst = 1'b0;
            n_checks++;
            if (Q !== m_q || Qbar !== ~m_q || upd !== m_upd) begin
                n_fail++;
                $display("FAIL random[%0d]: Q=%h Qbar=%h upd=%b, want Q=%h Qbar=%h upd=%b",
                         i, Q, Qbar, upd, m_q, ~m_q, m_upd);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        D     = '0;
        EN    = 1'b0;
        m_q   = '0;
        m_upd = 1'b0;
        test_reset();
        test_track();
        test_hold();
        test_reenable();
        test_simultaneous();
        test_async_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
